// File: rtl/tdm_mux4_tx.sv
// rtl/tdm_mux4_tx.sv - four-channel TDM transmitter with slot select and frame handshakes
module tdm_mux4_tx #(
  parameter int W           = 1,
  parameter int SLOT_CYCLES = 1,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  output logic [W-1:0] o,
  output logic [1:0]   s,
  output logic         valid,
  output logic         frame,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [7:0] DWELL_LAST = 8'(SLOT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0][W-1:0]   snap_q, snap_d;
  logic [1:0]          slot_q, slot_d;
  logic [7:0]          dwell_q, dwell_d;
  logic [W-1:0]        o_q, o_d;
  logic [1:0]          s_q, s_d;
  logic                valid_q, valid_d;
  logic                frame_q, frame_d;
  logic                done_q, done_d;

  // State, snapshot, counters and the output flops; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      slot_q  <= '0;
      dwell_q <= '0;
      o_q     <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      slot_q  <= slot_d;
      dwell_q <= dwell_d;
      o_q     <= o_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // Next state plus the output values for the coming cycle, so every output is a flop.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    slot_d  = slot_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          snap_d  = {i3, i2, i1, i0};
          slot_d  = 2'd0;
          dwell_d = 8'd0;
        end
      end
      SEND: begin
        // done_q marks the final cycle of slot 3: the only point where start is honoured.
        if (done_q) begin
          slot_d  = 2'd0;
          dwell_d = 8'd0;
          if (CONTINUOUS || start) begin
            snap_d = {i3, i2, i1, i0};
          end else begin
            state_d = IDLE;
          end
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
          slot_d  = slot_q + 2'd1;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    o_d     = '0;
    s_d     = 2'd0;
    valid_d = 1'b0;
    frame_d = 1'b0;
    done_d  = 1'b0;
    if (state_d == SEND) begin
      o_d     = snap_d[slot_d];
      s_d     = slot_d;
      valid_d = 1'b1;
      frame_d = (slot_d == 2'd0) && (dwell_d == 8'd0);
      done_d  = (slot_d == 2'd3) && (dwell_d == DWELL_LAST);
    end
  end

  assign o     = o_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign busy  = valid_q;
  assign frame = frame_q;
  assign done  = done_q;

endmodule
